// File: rtl/bp_me_pkg.sv
// bp_me_pkg: processor configs, BedRock widths, stream states and mem-if monitor error codes.
package bp_me_pkg;
  typedef enum logic [1:0] {e_bp_default_cfg, e_bp_unicore_cfg} bp_params_e;
  typedef enum logic [2:0] {
    e_err_none,
    e_err_cmd_unstable,
    e_err_resp_unstable,
    e_err_cmd_hdr_mismatch,
    e_err_resp_hdr_mismatch,
    e_err_overflow,
    e_err_underflow,
    e_err_timeout
  } bp_mem_if_monitor_err_e;
  typedef enum logic {e_idle, e_stream} bp_mem_stream_state_e;
  localparam int bedrock_data_width_gp = 64;
  function automatic int mem_header_width(bp_params_e cfg);
    return (cfg == e_bp_unicore_cfg) ? 66 : 64;
  endfunction
endpackage

// File: rtl/bp_nonsynth_mem_stream_checker.sv
// bp_nonsynth_mem_stream_checker: per-channel valid/ready stability and multi-beat header consistency flags.
module bp_nonsynth_mem_stream_checker
  import bp_me_pkg::*;
 #(parameter int header_width_p = 64
  ,parameter int data_width_p = 64
  )
  (input  logic                      clk_i
  ,input  logic                      reset_i
  ,input  logic [header_width_p-1:0] header_i
  ,input  logic [data_width_p-1:0]   data_i
  ,input  logic                      v_i
  ,input  logic                      ready_and_i
  ,input  logic                      last_i
  ,output logic                      unstable_o
  ,output logic                      mismatch_o
  );
  bp_mem_stream_state_e state_r, state_n;
  logic [header_width_p-1:0] hdr_r, prev_hdr_r;
  logic [data_width_p-1:0] prev_data_r;
  logic prev_stall_r, prev_last_r, accept;
  assign accept = v_i & ready_and_i;
  // A stalled beat must be re-presented unchanged until it is taken
  assign unstable_o = prev_stall_r & (~v_i | (header_i != prev_hdr_r) | (data_i != prev_data_r) | (last_i != prev_last_r));
  assign mismatch_o = (state_r == e_stream) & accept & (header_i != hdr_r);
  always_comb
    state_n = (state_r == e_idle) ? ((accept & ~last_i) ? e_stream : e_idle)
                                  : ((accept & last_i) ? e_idle : e_stream);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      hdr_r <= '0;
      prev_stall_r <= 1'b0;
      prev_hdr_r <= '0;
      prev_data_r <= '0;
      prev_last_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if ((state_r == e_idle) & accept & ~last_i) hdr_r <= header_i;
      prev_stall_r <= v_i & ~ready_and_i;
      prev_hdr_r <= header_i;
      prev_data_r <= data_i;
      prev_last_r <= last_i;
    end
  end
endmodule

// File: rtl/bp_nonsynth_mem_if_monitor.sv
// bp_nonsynth_mem_if_monitor: tracks in-flight mem commands and latches the first protocol error.
// Define BP_MEM_IF_MONITOR_TRACE_EN to print every accepted beat and the first captured error.
module bp_nonsynth_mem_if_monitor
  import bp_me_pkg::*;
 #(parameter bp_params_e bp_params_p = e_bp_default_cfg
  ,parameter int max_outstanding_p = 16
  ,parameter int timeout_cycles_p = 4096
  ,localparam int mem_header_width_lp = mem_header_width(bp_params_p)
  ,localparam int bedrock_data_width_p = bedrock_data_width_gp
  ,localparam int out_width_lp = $clog2(max_outstanding_p+1)
  ,localparam int tmo_width_lp = $clog2(timeout_cycles_p+1)
  )
  (input  logic                            clk_i
  ,input  logic                            reset_i
  ,input  logic [mem_header_width_lp-1:0]  mem_cmd_header_i
  ,input  logic [bedrock_data_width_p-1:0] mem_cmd_data_i
  ,input  logic                            mem_cmd_v_i
  ,input  logic                            mem_cmd_ready_and_i
  ,input  logic                            mem_cmd_last_i
  ,input  logic [mem_header_width_lp-1:0]  mem_resp_header_i
  ,input  logic [bedrock_data_width_p-1:0] mem_resp_data_i
  ,input  logic                            mem_resp_v_i
  ,input  logic                            mem_resp_ready_and_i
  ,input  logic                            mem_resp_last_i
  ,output logic [out_width_lp-1:0]         outstanding_o
  ,output logic                            error_o
  ,output logic [2:0]                      error_code_o
  );
  logic cmd_unstable, cmd_mismatch, resp_unstable, resp_mismatch;
  logic cmd_done, resp_acc, resp_done, overflow, underflow, timeout;
  logic [tmo_width_lp-1:0] idle_cnt_r;
  bp_mem_if_monitor_err_e err_code_r, err_n;
  bp_nonsynth_mem_stream_checker #(.header_width_p(mem_header_width_lp), .data_width_p(bedrock_data_width_p)) cmd_chk
    (.clk_i(clk_i), .reset_i(reset_i), .header_i(mem_cmd_header_i), .data_i(mem_cmd_data_i)
    ,.v_i(mem_cmd_v_i), .ready_and_i(mem_cmd_ready_and_i), .last_i(mem_cmd_last_i)
    ,.unstable_o(cmd_unstable), .mismatch_o(cmd_mismatch));
  bp_nonsynth_mem_stream_checker #(.header_width_p(mem_header_width_lp), .data_width_p(bedrock_data_width_p)) resp_chk
    (.clk_i(clk_i), .reset_i(reset_i), .header_i(mem_resp_header_i), .data_i(mem_resp_data_i)
    ,.v_i(mem_resp_v_i), .ready_and_i(mem_resp_ready_and_i), .last_i(mem_resp_last_i)
    ,.unstable_o(resp_unstable), .mismatch_o(resp_mismatch));
  assign cmd_done = mem_cmd_v_i & mem_cmd_ready_and_i & mem_cmd_last_i;
  assign resp_acc = mem_resp_v_i & mem_resp_ready_and_i;
  assign resp_done = resp_acc & mem_resp_last_i;
  assign overflow = cmd_done & ~resp_done & (outstanding_o == out_width_lp'(max_outstanding_p));
  assign underflow = resp_done & ~cmd_done & (outstanding_o == '0);
  assign timeout = idle_cnt_r == tmo_width_lp'(timeout_cycles_p);
  assign error_code_o = err_code_r;
  // Lowest code wins when several errors coincide
  always_comb
    err_n = cmd_unstable  ? e_err_cmd_unstable
          : resp_unstable ? e_err_resp_unstable
          : cmd_mismatch  ? e_err_cmd_hdr_mismatch
          : resp_mismatch ? e_err_resp_hdr_mismatch
          : overflow      ? e_err_overflow
          : underflow     ? e_err_underflow
          : timeout       ? e_err_timeout
          : e_err_none;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      outstanding_o <= '0;
      idle_cnt_r <= '0;
      error_o <= 1'b0;
      err_code_r <= e_err_none;
    end else begin
      if (cmd_done & ~resp_done & ~overflow) outstanding_o <= outstanding_o + 1'b1;
      else if (resp_done & ~cmd_done & ~underflow) outstanding_o <= outstanding_o - 1'b1;
      idle_cnt_r <= (resp_acc | (outstanding_o == '0)) ? '0 : timeout ? idle_cnt_r : idle_cnt_r + 1'b1;
      if (~error_o & (err_n != e_err_none)) begin
        error_o <= 1'b1;
        err_code_r <= err_n;
      end
    end
  end
`ifdef BP_MEM_IF_MONITOR_TRACE_EN
  logic [63:0] cycle_r;
  always_ff @(posedge clk_i) begin
    cycle_r <= reset_i ? '0 : cycle_r + 1'b1;
    if (~reset_i & mem_cmd_v_i & mem_cmd_ready_and_i)
      $display("[mem_if] cmd  cycle=%0d header=%h last=%b", cycle_r, mem_cmd_header_i, mem_cmd_last_i);
    if (~reset_i & resp_acc)
      $display("[mem_if] resp cycle=%0d header=%h last=%b", cycle_r, mem_resp_header_i, mem_resp_last_i);
    if (~reset_i & ~error_o & (err_n != e_err_none))
      $error("[mem_if] error cycle=%0d code=%0d (%s)", cycle_r, err_n, err_n.name());
  end
`endif
endmodule

// File: tb/tb_bp_nonsynth_mem_if_monitor.sv
// tb_bp_nonsynth_mem_if_monitor: directed plus random checks of two monitor configurations against a reference model.
module tb_bp_nonsynth_mem_if_monitor;
  logic clk = 1'b0;
  logic rst;
  logic cv, cr, cl, rv, rr, rl;
  logic [63:0] ch, cd, rh, rd;
  logic [4:0] oa;
  logic [1:0] ob;
  logic ea, eb;
  logic [2:0] ca, cb;
  int checks = 0;
  int fails = 0;
  int maxo [2] = '{16, 2};
  int tout [2] = '{4096, 8};
  int m_out [2];
  int m_sil [2];
  int m_err [2];
  bit p_stall [2];
  bit p_l [2];
  bit in_msg [2];
  logic [63:0] p_h [2];
  logic [63:0] p_d [2];
  logic [63:0] lat [2];

  always #5 clk = ~clk;

  bp_nonsynth_mem_if_monitor da
    (.clk_i(clk), .reset_i(rst)
    ,.mem_cmd_header_i(ch), .mem_cmd_data_i(cd), .mem_cmd_v_i(cv), .mem_cmd_ready_and_i(cr), .mem_cmd_last_i(cl)
    ,.mem_resp_header_i(rh), .mem_resp_data_i(rd), .mem_resp_v_i(rv), .mem_resp_ready_and_i(rr), .mem_resp_last_i(rl)
    ,.outstanding_o(oa), .error_o(ea), .error_code_o(ca));

  bp_nonsynth_mem_if_monitor #(.max_outstanding_p(2), .timeout_cycles_p(8)) db
    (.clk_i(clk), .reset_i(rst)
    ,.mem_cmd_header_i(ch), .mem_cmd_data_i(cd), .mem_cmd_v_i(cv), .mem_cmd_ready_and_i(cr), .mem_cmd_last_i(cl)
    ,.mem_resp_header_i(rh), .mem_resp_data_i(rd), .mem_resp_v_i(rv), .mem_resp_ready_and_i(rr), .mem_resp_last_i(rl)
    ,.outstanding_o(ob), .error_o(eb), .error_code_o(cb));

  task automatic expect_val(input string tag, input logic [31:0] got, input int exp);
    checks++;
    assert (got === 32'(exp)) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Applies the protocol rules to the inputs about to be sampled at the next edge
  task automatic model_step();
    bit v [2];
    bit r [2];
    bit l [2];
    logic [63:0] h [2];
    logic [63:0] d [2];
    bit uns [2];
    bit mm [2];
    bit acc [2];
    bit done [2];
    v = '{cv, rv}; r = '{cr, rr}; l = '{cl, rl}; h = '{ch, rh}; d = '{cd, rd};
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_out[c] = 0; m_sil[c] = 0; m_err[c] = 0;
        p_stall[c] = 0; p_l[c] = 0; in_msg[c] = 0; p_h[c] = '0; p_d[c] = '0; lat[c] = '0;
      end
      return;
    end
    for (int c = 0; c < 2; c++) begin
      acc[c] = v[c] && r[c];
      done[c] = acc[c] && l[c];
      uns[c] = p_stall[c] && (!v[c] || h[c] !== p_h[c] || d[c] !== p_d[c] || l[c] != p_l[c]);
      mm[c] = in_msg[c] && acc[c] && h[c] !== lat[c];
    end
    for (int i = 0; i < 2; i++) begin
      int code;
      bit ov, un, to;
      ov = done[0] && !done[1] && m_out[i] == maxo[i];
      un = done[1] && !done[0] && m_out[i] == 0;
      to = m_sil[i] == tout[i];
      code = uns[0] ? 1 : uns[1] ? 2 : mm[0] ? 3 : mm[1] ? 4 : ov ? 5 : un ? 6 : to ? 7 : 0;
      if (m_err[i] == 0) m_err[i] = code;
      if (acc[1] || m_out[i] == 0) m_sil[i] = 0;
      else if (m_sil[i] < tout[i]) m_sil[i]++;
      if (done[0] && !done[1] && !ov) m_out[i]++;
      else if (done[1] && !done[0] && !un) m_out[i]--;
    end
    for (int c = 0; c < 2; c++) begin
      if (acc[c] && !in_msg[c] && !l[c]) begin in_msg[c] = 1; lat[c] = h[c]; end
      else if (acc[c] && in_msg[c] && l[c]) in_msg[c] = 0;
      p_stall[c] = v[c] && !r[c];
      p_h[c] = h[c]; p_d[c] = d[c]; p_l[c] = l[c];
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    expect_val("a_outstanding", oa, m_out[0]);
    expect_val("a_error", ea, m_err[0] != 0);
    expect_val("a_code", ca, m_err[0]);
    expect_val("b_outstanding", ob, m_out[1]);
    expect_val("b_error", eb, m_err[1] != 0);
    expect_val("b_code", cb, m_err[1]);
  endtask

  task automatic set_cmd(input logic v, input logic r, input logic l, input logic [63:0] h);
    cv = v; cr = r; cl = l; ch = h; cd = h ^ 64'h5a5a;
  endtask

  task automatic set_resp(input logic v, input logic r, input logic l, input logic [63:0] h);
    rv = v; rr = r; rl = l; rh = h; rd = h ^ 64'ha5a5;
  endtask

  task automatic rand_chan(inout logic v, inout logic r, inout logic l, inout logic [63:0] h, inout logic [63:0] d);
    if (!(v && !r && $urandom_range(3) != 0)) begin
      v = 1'($urandom_range(1));
      l = 1'($urandom_range(1));
      h = 64'($urandom_range(1));
      d = 64'($urandom_range(1));
    end
    r = 1'($urandom_range(1));
  endtask

  initial begin
    int rise;
    rst = 1'b1;
    set_cmd(0, 1, 1, '0);
    set_resp(0, 1, 1, '0);
    cyc(); cyc();
    expect_val("reset_a_code", ca, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_cmd(1, 1, 1, 64'(k));
      cyc();
      expect_val("seq_cmd_out", oa, k + 1);
    end
    expect_val("b_overflow_code", cb, 5);
    expect_val("b_overflow_sat", ob, 2);
    set_resp(1, 1, 1, 64'h77);
    cyc();
    expect_val("pair_hold", oa, 3);
    set_cmd(0, 1, 1, '0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      expect_val("seq_resp_out", oa, 2 - k);
    end
    expect_val("seq_no_error", ea, 0);
    set_resp(0, 1, 1, '0);
    rst = 1'b1; cyc(); rst = 1'b0;
    set_cmd(1, 1, 1, 64'h42);
    cyc();
    set_cmd(0, 1, 1, '0);
    rise = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (eb === 1'b1 && rise == 0) rise = n;
    end
    expect_val("timeout_latency", rise, 9);
    expect_val("timeout_code", cb, 7);
    expect_val("timeout_a_clean", ea, 0);
    rst = 1'b1; cyc(); rst = 1'b0;
    set_cmd(1, 0, 1, 64'h5);
    cyc();
    expect_val("stall_no_err", ca, 0);
    set_cmd(0, 1, 1, 64'h5);
    cyc();
    expect_val("unstable_code", ca, 1);
    set_cmd(0, 1, 1, '0);
    cyc(); cyc();
    expect_val("unstable_sticky", ca, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    set_cmd(1, 1, 1, 64'h9);
    cyc();
    set_cmd(0, 1, 1, '0);
    for (int b = 0; b < 4; b++) begin
      set_resp(1, 1, 1'(b == 3), (b == 2) ? 64'hbeef : 64'hbee0);
      cyc();
    end
    set_resp(0, 1, 1, '0);
    cyc();
    expect_val("resp_mismatch_code", ca, 4);
    expect_val("resp_mismatch_b", cb, 4);
    for (int b = 0; b < 2; b++) begin
      set_cmd(1, 1, 0, 64'hc0de);
      cyc();
    end
    rst = 1'b1;
    cyc(); cyc();
    expect_val("midreset_err", ea, 0);
    expect_val("midreset_code", ca, 0);
    expect_val("midreset_out", oa, 0);
    rst = 1'b0;
    set_cmd(1, 1, 1, 64'hf00d);
    cyc();
    set_cmd(0, 1, 1, '0);
    expect_val("post_reset_out", oa, 1);
    expect_val("post_reset_err", ea, 0);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(63) == 0);
      rand_chan(cv, cr, cl, ch, cd);
      rand_chan(rv, rr, rl, rh, rd);
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
